seq_serializer: RTL and testbench

Parallel-to-serial stage that feeds the serial sequence detectors (`in`/`out` Mealy FSMs) one bit per clock. Accepts W-bit words over a valid/ready handshake, buffers one word so consecutive words stream without bubbles, and shifts each word out as `ser_out`/`ser_valid`, with a programmable idle gap between words. Non-valid cycles drive `ser_out` to 0 so a downstream detector sees idle zeros.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_serializer.sv | 119 +++++++++++
 tb/tb_seq_serializer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared FSM state encoding and gap counter width
package seq_pkg;

  // State encoding shared by the serializer and the serial sequence detectors
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_state_t;

  // Width of the inter-word idle gap counter (gap lengths 0..15)
  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial stage with one-word hold buffer and idle gap
module seq_serializer
  import seq_pkg::*;
#(
  parameter int W          = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last,
  output logic         busy
);

  localparam int                   BW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0]        LAST_BIT = BW'(W - 1);
  localparam bit                   HAS_GAP  = (GAP_CYCLES > 0);
  // Gap counter counts down to zero, so GAP lasts GAP_CYCLES cycles
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = HAS_GAP ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  seq_state_t           state;
  logic [W-1:0]         shreg;
  logic [W-1:0]         hold;
  logic                 hold_full;
  logic [BW-1:0]        bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;

  logic accept;
  logic word_end;
  logic gap_end;
  logic reload_pt;
  logic to_hold;

  // Handshake and word-boundary decode; reload_pt marks the edge where the next word may start
  always_comb begin
    accept    = din_valid && !hold_full;
    word_end  = (state == SHIFT) && (bit_cnt == LAST_BIT);
    gap_end   = (state == GAP) && (gap_cnt == '0);
    reload_pt = (word_end && !HAS_GAP) || gap_end;
    // An accepted word bypasses the hold register only when it is loaded straight into the shifter
    to_hold   = accept && (state != IDLE) && !(reload_pt && !hold_full);
  end

  // Outputs decode from registers only, so din_valid never reaches them combinationally
  assign din_ready = !hold_full;
  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid && (MSB_FIRST ? shreg[W-1] : shreg[0]);
  assign ser_last  = word_end;
  assign busy      = (state != IDLE) || hold_full;

  // Serializer FSM, shifter, counters and hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= din;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= MSB_FIRST ? {shreg[W-2:0], 1'b0} : {1'b0, shreg[W-1:1]};
          bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
          if (word_end) begin
            if (HAS_GAP) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else if (hold_full) begin
              shreg <= hold;
            end else if (accept) begin
              shreg <= din;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            bit_cnt <= '0;
            if (hold_full) begin
              shreg <= hold;
              state <= SHIFT;
            end else if (accept) begin
              shreg <= din;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Hold register: a new word replaces a reloaded one, otherwise a reload empties it
      if (to_hold) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (reload_pt && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - self-checking bench for seq_serializer with a word-level model
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_a [3];
  logic [2:0] dv_a = 3'b000;
  logic [2:0] dr_a, so_a, sv_a, sl_a, bz_a;

  always #5 clk = ~clk;

  // Instance 0: MSB first, no gap; 1: LSB first, no gap; 2: MSB first, gap of 2
  seq_serializer #(.W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .din(din_a[0]), .din_valid(dv_a[0]), .din_ready(dr_a[0]),
    .ser_out(so_a[0]), .ser_valid(sv_a[0]), .ser_last(sl_a[0]), .busy(bz_a[0]));
  seq_serializer #(.W(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .din(din_a[1]), .din_valid(dv_a[1]), .din_ready(dr_a[1]),
    .ser_out(so_a[1]), .ser_valid(sv_a[1]), .ser_last(sl_a[1]), .busy(bz_a[1]));
  seq_serializer #(.W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .din(din_a[2]), .din_valid(dv_a[2]), .din_ready(dr_a[2]),
    .ser_out(so_a[2]), .ser_valid(sv_a[2]), .ser_last(sl_a[2]), .busy(bz_a[2]));

  int gapp [3] = '{0, 0, 2};
  int msbp [3] = '{1, 0, 1};

  // Word-level model: bits left in the current word, gap cycles left, one waiting word
  int         m_bits  [3];
  int         m_gap   [3];
  logic       m_wfull [3];
  logic [7:0] m_word  [3];
  logic [7:0] m_wword [3];
  logic [2:0] acc;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [63:0] stream [3];
  int          vcnt   [3];
  int          first_v[3];
  int          last_v [3];

  logic [7:0] fq[$];
  int         acc_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic m_busy(input int i);
    return (m_bits[i] > 0) || (m_gap[i] > 0) || m_wfull[i];
  endfunction

  // Advance the model across the coming edge using the inputs currently applied
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      logic a;
      logic reload;
      acc[i] = 1'b0;
      if (rst) begin
        m_bits[i]  = 0;
        m_gap[i]   = 0;
        m_wfull[i] = 1'b0;
      end else begin
        a      = dv_a[i] && !m_wfull[i];
        acc[i] = a;
        reload = 1'b0;
        if (m_bits[i] > 0) begin
          m_bits[i]--;
          if (m_bits[i] == 0) begin
            if (gapp[i] > 0) m_gap[i] = gapp[i];
            else reload = 1'b1;
          end
        end else if (m_gap[i] > 0) begin
          m_gap[i]--;
          if (m_gap[i] == 0) reload = 1'b1;
        end else if (a) begin
          m_word[i] = din_a[i];
          m_bits[i] = 8;
          a = 1'b0;
        end
        if (reload) begin
          if (m_wfull[i]) begin
            m_word[i]  = m_wword[i];
            m_bits[i]  = 8;
            m_wfull[i] = 1'b0;
          end else if (a) begin
            m_word[i] = din_a[i];
            m_bits[i] = 8;
            a = 1'b0;
          end
        end
        if (a) begin
          m_wword[i] = din_a[i];
          m_wfull[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic ev, eb;
      int   k;
      ev = (m_bits[i] > 0);
      eb = 1'b0;
      if (ev) begin
        k  = 8 - m_bits[i];
        eb = (msbp[i] != 0) ? m_word[i][7-k] : m_word[i][k];
      end
      chk($sformatf("ser_valid[%0d]", i), sv_a[i], ev);
      chk($sformatf("ser_out[%0d]", i), so_a[i], eb);
      chk($sformatf("ser_last[%0d]", i), sl_a[i], m_bits[i] == 1);
      chk($sformatf("busy[%0d]", i), bz_a[i], m_busy(i));
      chk($sformatf("din_ready[%0d]", i), dr_a[i], !m_wfull[i]);
    end
  endtask

  task automatic clear_rec();
    for (int i = 0; i < 3; i++) begin
      stream[i] = '0; vcnt[i] = 0; first_v[i] = -1; last_v[i] = -1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare_all();
    for (int i = 0; i < 3; i++) begin
      if (sv_a[i]) begin
        stream[i] = {stream[i][62:0], so_a[i]};
        vcnt[i]++;
        if (first_v[i] < 0) first_v[i] = cyc;
        last_v[i] = cyc;
      end
    end
  endtask

  // Present queued words on one instance back to back and run until it drains
  task automatic feed(input int i, input int maxc);
    int c = 0;
    acc_cyc.delete();
    while ((fq.size() > 0 || m_busy(i)) && c < maxc) begin
      dv_a[i]  = (fq.size() > 0);
      din_a[i] = (fq.size() > 0) ? fq[0] : 8'h00;
      cycle();
      if (acc[i]) begin
        acc_cyc.push_back(cyc);
        void'(fq.pop_front());
      end
      c++;
    end
    dv_a[i] = 1'b0;
    if (c >= maxc) chk("feed_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic obs_out [11];
    logic obs_last[11];
    logic obs_busy[11];
    logic [7:0] lastv;
    int t0;

    for (int i = 0; i < 3; i++) begin
      din_a[i] = 8'h00; m_bits[i] = 0; m_gap[i] = 0; m_wfull[i] = 1'b0;
      m_word[i] = 8'h00; m_wword[i] = 8'h00;
    end
    acc = 3'b000;
    clear_rec();

    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("reset_din_ready", dr_a, 3'b111);
    chk("reset_busy", bz_a, 3'b000);
    chk("reset_ser_valid", sv_a, 3'b000);

    // Single word 0xD0, MSB first
    din_a[0] = 8'hD0; dv_a[0] = 1'b1;
    cycle();
    chk("d0_accepted", acc[0], 1'b1);
    dv_a[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      obs_out[k] = so_a[0]; obs_last[k] = sl_a[0]; obs_busy[k] = bz_a[0];
      cycle();
    end
    begin
      logic [7:0] bits;
      logic [7:0] lasts;
      for (int k = 1; k <= 8; k++) begin
        bits[8-k]  = obs_out[k];
        lasts[8-k] = obs_last[k];
      end
      chk("d0_bits", bits, 8'b1101_0000);
      chk("d0_last_only_at_8", {lasts, obs_last[9]}, 9'b0000_0001_0);
      chk("d0_busy_at_8", obs_busy[8], 1'b1);
      chk("d0_busy_drop_at_9", obs_busy[9], 1'b0);
    end

    // Back-to-back words, no gap
    clear_rec();
    fq = '{8'hDD, 8'hB4};
    feed(0, 100);
    chk("b2b_stream", stream[0][15:0], 16'hDDB4);
    chk("b2b_contiguous", last_v[0] - first_v[0] + 1, 16);

    // Backpressure with three words presented continuously
    clear_rec();
    fq = '{8'h11, 8'h22, 8'h33};
    feed(0, 100);
    chk("bp_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("bp_w2_next_edge", acc_cyc[1] - acc_cyc[0], 1);
      chk("bp_w3_after_reload", acc_cyc[2] - acc_cyc[0], 9);
    end
    chk("bp_stream", stream[0][23:0], 24'h112233);
    chk("bp_count", vcnt[0], 24);
    chk("bp_contiguous", last_v[0] - first_v[0] + 1, 24);

    // Gap of two idle cycles between words
    clear_rec();
    fq = '{8'h0D, 8'hF0};
    feed(2, 100);
    chk("gap_stream", stream[2][15:0], 16'h0DF0);
    chk("gap_idle_cycles", (last_v[2] - first_v[2] + 1) - vcnt[2], 2);

    // LSB first
    clear_rec();
    fq = '{8'h0B};
    feed(1, 100);
    lastv = stream[1][7:0];
    chk("lsb_first_bits", lastv, 8'b1101_0000);

    // Reset during bit 4 with a word held
    clear_rec();
    din_a[0] = 8'hD0; dv_a[0] = 1'b1;
    cycle();
    t0 = cyc;
    din_a[0] = 8'hA5;
    cycle();
    chk("rst_hold_taken", acc[0], 1'b1);
    dv_a[0] = 1'b0;
    while (cyc - t0 < 4) cycle();
    chk("rst_ready_low_before", dr_a[0], 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_outputs_zero", {so_a[0], sv_a[0], sl_a[0], bz_a[0]}, 4'b0000);
    chk("rst_ready_high", dr_a[0], 1'b1);
    clear_rec();
    fq = '{8'h3C};
    feed(0, 100);
    chk("post_rst_stream", stream[0][7:0], 8'h3C);
    chk("post_rst_count", vcnt[0], 8);

    // Randomized traffic on all instances with occasional resets
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!dv_a[i] || acc[i]) begin
          dv_a[i]  = ($urandom_range(0, 3) != 0);
          din_a[i] = 8'($urandom);
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst  = 1'b0;
    dv_a = 3'b000;
    repeat (40) cycle();
    chk("drain_idle", bz_a, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
